mq_pass_length_record: RTL and testbench

Records MQ coder output byte counts at every coding-pass boundary of a code-block and queues them for tier-2 truncation and packet headers. Sits directly downstream of the MQ output state generator. Consumes its `word_last_sp/mrp/cp` levels and `bp_code_over` pulse, plus the MQ byte strobe. Emits a ready/valid stream of per-pass records ending with one final-length record.

---
 rtl/mq_pkg.sv | 26 ++
 rtl/mq_pass_length_record_fifo.sv | 47 ++++
 rtl/mq_pass_length_record.sv | 188 ++++++++++++++++++
 tb/tb_mq_pass_length_record.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mq_pkg.sv
// Shared pass codes, record layout and FSM encoding for the MQ pass-length recorder.
package mq_pkg;

  localparam logic [1:0] PASS_FIN = 2'b00;
  localparam logic [1:0] PASS_SP  = 2'b01;
  localparam logic [1:0] PASS_MRP = 2'b10;
  localparam logic [1:0] PASS_CP  = 2'b11;

  // Record layout, MSB first: {final, pass[1:0], plane[BP_W-1:0], len[LEN_W-1:0]}
  localparam int unsigned REC_HDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } rec_state_e;

  function automatic logic [1:0] pass_after(input logic [1:0] p);
    case (p)
      PASS_CP: return PASS_SP;
      PASS_SP: return PASS_MRP;
      default: return PASS_CP;
    endcase
  endfunction

endpackage

// File: rtl/mq_pass_length_record_fifo.sv
// Generic first-word fall-through synchronous FIFO; a write while full is
// accepted only when a read happens in the same cycle.
module pass_rec_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd    = rd_en && !empty;
  assign w_wr    = wr_en && (!full || w_rd);
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mq_pass_length_record.sv
// Records cumulative MQ byte counts at each coding-pass end of a code-block and
// queues them, followed by one final-length record, for tier-2 consumers.
module mq_pass_length_record
  import mq_pkg::*;
#(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned BP_W  = 5,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_syn,
  input  logic             byte_valid,
  input  logic             word_last_sp,
  input  logic             word_last_mrp,
  input  logic             word_last_cp,
  input  logic             bp_code_over,
  input  logic [BP_W-1:0]  msb_plane,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [1:0]       rec_pass,
  output logic [BP_W-1:0]  rec_plane,
  output logic [LEN_W-1:0] rec_len,
  output logic             rec_final,
  output logic             overflow,
  output logic             proto_err,
  output logic             cb_done
);

  localparam int unsigned REC_W = REC_HDR_W + BP_W + LEN_W;

  rec_state_e       r_state;
  rec_state_e       w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [BP_W-1:0]  r_plane;
  logic [BP_W-1:0]  w_plane_nxt;
  logic [1:0]       r_exp;
  logic             r_wl_sp;
  logic             r_wl_mrp;
  logic             r_wl_cp;
  logic             r_fin_pend;
  logic [REC_W-1:0] r_fin_rec;
  logic             r_overflow;
  logic             r_proto_err;
  logic             r_cb_done;

  logic             w_run;
  logic             w_drain;
  logic             w_e_sp;
  logic             w_e_mrp;
  logic             w_e_cp;
  logic             w_ev;
  logic             w_multi;
  logic [1:0]       w_ev_pass;
  logic             w_fin_now;
  logic             w_err;
  logic [REC_W-1:0] w_ev_rec;
  logic [REC_W-1:0] w_fin_rec;
  logic             w_push;
  logic [REC_W-1:0] w_wdata;
  logic [REC_W-1:0] w_rd_data;
  logic [REC_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_fin_pop;

  assign w_run   = (r_state == ST_RUN);
  assign w_drain = (r_state == ST_DRAIN);

  assign w_e_sp  = w_run && word_last_sp  && !r_wl_sp;
  assign w_e_mrp = w_run && word_last_mrp && !r_wl_mrp;
  assign w_e_cp  = w_run && word_last_cp  && !r_wl_cp;
  assign w_ev    = w_e_sp || w_e_mrp || w_e_cp;
  assign w_multi = (w_e_sp && w_e_mrp) || (w_e_sp && w_e_cp) || (w_e_mrp && w_e_cp);
  assign w_ev_pass = w_e_cp ? PASS_CP : (w_e_mrp ? PASS_MRP : PASS_SP);

  assign w_cnt_nxt = (w_run && byte_valid && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
  assign w_plane_nxt = (w_ev && w_ev_pass == PASS_CP && r_plane != '0) ? r_plane - 1'b1
                                                                        : r_plane;

  assign w_fin_now = w_run && bp_code_over;
  assign w_ev_rec  = {1'b0, w_ev_pass, r_plane, w_cnt_nxt};
  // The final record follows any same-cycle pass edge, so it sees the updated plane.
  assign w_fin_rec = {1'b1, PASS_FIN, w_plane_nxt, w_cnt_nxt};

  assign w_err = (w_ev && (w_multi || w_ev_pass != r_exp)) || (w_drain && byte_valid);

  // Single FIFO write port: pass edge, else direct final, else deferred final.
  always_comb begin
    w_push  = 1'b0;
    w_wdata = w_ev_rec;
    if (w_ev) begin
      w_push = 1'b1;
    end else if (w_fin_now) begin
      w_push  = 1'b1;
      w_wdata = w_fin_rec;
    end else if (r_fin_pend) begin
      w_push  = 1'b1;
      w_wdata = r_fin_rec;
    end
  end

  pass_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (rst_syn),
    .wr_en   (w_push),
    .wr_data (w_wdata),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_head    = {REC_W{~w_empty}} & w_rd_data;
  assign w_pop     = !w_empty && rec_ready;
  assign w_fin_pop = w_drain && w_pop && w_head[REC_W-1];

  always_comb begin
    w_state_nxt = r_state;
    if (rst_syn) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:   if (bp_code_over) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_fin_pop)    w_state_nxt = ST_IDLE;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_plane     <= '0;
      r_exp       <= PASS_CP;
      r_wl_sp     <= 1'b0;
      r_wl_mrp    <= 1'b0;
      r_wl_cp     <= 1'b0;
      r_fin_pend  <= 1'b0;
      r_fin_rec   <= '0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
      r_cb_done   <= 1'b0;
    end else if (rst_syn) begin
      r_state     <= w_state_nxt;
      r_cnt       <= '0;
      r_plane     <= msb_plane;
      r_exp       <= PASS_CP;
      r_wl_sp     <= 1'b0;
      r_wl_mrp    <= 1'b0;
      r_wl_cp     <= 1'b0;
      r_fin_pend  <= 1'b0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
      r_cb_done   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_plane    <= w_plane_nxt;
      r_wl_sp    <= word_last_sp;
      r_wl_mrp   <= word_last_mrp;
      r_wl_cp    <= word_last_cp;
      r_fin_pend <= w_fin_now && w_ev;
      r_cb_done  <= w_fin_pop;
      if (w_ev)      r_exp     <= pass_after(w_ev_pass);
      if (w_fin_now) r_fin_rec <= w_fin_rec;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_err) r_proto_err <= 1'b1;
    end
  end

  assign rec_valid = !w_empty;
  assign rec_final = w_head[REC_W-1];
  assign rec_pass  = w_head[LEN_W+BP_W +: 2];
  assign rec_plane = w_head[LEN_W +: BP_W];
  assign rec_len   = w_head[LEN_W-1:0];
  assign overflow  = r_overflow;
  assign proto_err = r_proto_err;
  assign cb_done   = r_cb_done;

endmodule

// File: tb/tb_mq_pass_length_record.sv
// Directed bench for mq_pass_length_record; a LEN_W=4 copy shares the stimulus
// so counter saturation can be observed.
module tb_mq_pass_length_record;

  localparam int SP  = 0;
  localparam int MRP = 1;
  localparam int CP  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_syn = 1'b0;
  logic        byte_valid = 1'b0;
  logic        wl_sp = 1'b0;
  logic        wl_mrp = 1'b0;
  logic        wl_cp = 1'b0;
  logic        bp_code_over = 1'b0;
  logic [4:0]  msb_plane = '0;
  logic        rec_ready = 1'b0;

  logic        rec_valid;
  logic [1:0]  rec_pass;
  logic [4:0]  rec_plane;
  logic [15:0] rec_len;
  logic        rec_final;
  logic        overflow;
  logic        proto_err;
  logic        cb_done;

  logic        s_valid;
  logic [1:0]  s_pass;
  logic [4:0]  s_plane;
  logic [3:0]  s_len;
  logic        s_final;
  logic        s_overflow;
  logic        s_proto_err;
  logic        s_cb_done;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mq_pass_length_record #(.LEN_W(16), .BP_W(5), .DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .rst_syn(rst_syn), .byte_valid(byte_valid),
    .word_last_sp(wl_sp), .word_last_mrp(wl_mrp), .word_last_cp(wl_cp),
    .bp_code_over(bp_code_over), .msb_plane(msb_plane),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_pass(rec_pass),
    .rec_plane(rec_plane), .rec_len(rec_len), .rec_final(rec_final),
    .overflow(overflow), .proto_err(proto_err), .cb_done(cb_done)
  );

  mq_pass_length_record #(.LEN_W(4), .BP_W(5), .DEPTH(8)) u_sat (
    .clk(clk), .rst(rst), .rst_syn(rst_syn), .byte_valid(byte_valid),
    .word_last_sp(wl_sp), .word_last_mrp(wl_mrp), .word_last_cp(wl_cp),
    .bp_code_over(bp_code_over), .msb_plane(msb_plane),
    .rec_valid(s_valid), .rec_ready(rec_ready), .rec_pass(s_pass),
    .rec_plane(s_plane), .rec_len(s_len), .rec_final(s_final),
    .overflow(s_overflow), .proto_err(s_proto_err), .cb_done(s_cb_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic syn(input logic [4:0] msb);
    msb_plane = msb;
    rst_syn   = 1'b1;
    tick();
    rst_syn   = 1'b0;
  endtask

  task automatic bytes(input int n);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
  endtask

  // One pass-end pulse: level high for a cycle (optionally with a byte and
  // rec_ready), then low for a cycle.
  task automatic ev(input int which, input bit b, input bit rdy);
    byte_valid = b;
    rec_ready  = rdy;
    case (which)
      SP:      wl_sp  = 1'b1;
      MRP:     wl_mrp = 1'b1;
      default: wl_cp  = 1'b1;
    endcase
    tick();
    byte_valid = 1'b0;
    rec_ready  = 1'b0;
    wl_sp      = 1'b0;
    wl_mrp     = 1'b0;
    wl_cp      = 1'b0;
    tick();
  endtask

  task automatic pop(input string tag, input logic [1:0] p, input logic [4:0] pl,
                     input logic [15:0] len, input logic fin);
    chk({tag, ".valid"}, 32'(rec_valid), 32'd1);
    chk({tag, ".pass"},  32'(rec_pass),  32'(p));
    chk({tag, ".plane"}, 32'(rec_plane), 32'(pl));
    chk({tag, ".len"},   32'(rec_len),   32'(len));
    chk({tag, ".final"}, 32'(rec_final), 32'(fin));
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seq [3]   = '{CP, SP, MRP};
    logic [1:0]  bp_pass [8] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    logic [4:0]  bp_plane[8] = '{5'd6, 5'd6, 5'd6, 5'd5, 5'd5, 5'd5, 5'd4, 5'd4};

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.valid",   32'(rec_valid), 32'd0);
    chk("rst.len",     32'(rec_len),   32'd0);
    chk("rst.pass",    32'(rec_pass),  32'd0);
    chk("rst.final",   32'(rec_final), 32'd0);
    chk("rst.ovf",     32'(overflow),  32'd0);
    chk("rst.perr",    32'(proto_err), 32'd0);
    chk("rst.cbdone",  32'(cb_done),   32'd0);

    // Normal run
    syn(5'd2);
    bytes(5);
    ev(CP, 0, 0);
    bytes(3);
    ev(SP, 0, 0);
    bytes(2);
    ev(MRP, 0, 0);
    bytes(4);
    ev(CP, 0, 0);
    bytes(2);
    bp_code_over = 1'b1;
    tick();
    bp_code_over = 1'b0;
    chk("norm.perr", 32'(proto_err), 32'd0);
    pop("norm.r0", 2'b11, 5'd2, 16'd5,  1'b0);
    pop("norm.r1", 2'b01, 5'd1, 16'd8,  1'b0);
    pop("norm.r2", 2'b10, 5'd1, 16'd10, 1'b0);
    pop("norm.r3", 2'b11, 5'd1, 16'd14, 1'b0);
    chk("norm.cbdone_early", 32'(cb_done), 32'd0);
    pop("norm.fin", 2'b00, 5'd0, 16'd16, 1'b1);
    chk("norm.cbdone", 32'(cb_done), 32'd1);
    tick();
    chk("norm.cbdone_pulse", 32'(cb_done), 32'd0);
    chk("norm.empty", 32'(rec_valid), 32'd0);

    // Idle ignores pass edges
    ev(CP, 1, 0);
    chk("idle.ignore", 32'(rec_valid), 32'd0);

    // Same-cycle byte and CP edge
    syn(5'd3);
    bytes(3);
    byte_valid = 1'b1;
    wl_cp      = 1'b1;
    tick();
    chk("same.valid_n1", 32'(rec_valid), 32'd1);
    chk("same.len", 32'(rec_len), 32'd4);
    byte_valid = 1'b0;
    wl_cp      = 1'b0;
    tick();
    pop("same.cp", 2'b11, 5'd3, 16'd4, 1'b0);

    // Pass edge and flush in the same cycle; byte after flush
    byte_valid   = 1'b1;
    wl_sp        = 1'b1;
    bp_code_over = 1'b1;
    tick();
    byte_valid   = 1'b0;
    wl_sp        = 1'b0;
    bp_code_over = 1'b0;
    chk("coll.head_not_final", 32'(rec_final), 32'd0);
    tick();
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    chk("coll.perr_drain_byte", 32'(proto_err), 32'd1);
    pop("coll.sp",  2'b01, 5'd2, 16'd5, 1'b0);
    pop("coll.fin", 2'b00, 5'd2, 16'd5, 1'b1);
    chk("coll.cbdone", 32'(cb_done), 32'd1);

    // Backpressure: fill, push-with-pop when full, then drop
    syn(5'd7);
    for (int k = 0; k < 8; k++) ev(seq[k % 3], 1, 0);
    chk("bp.full_ovf", 32'(overflow), 32'd0);
    ev(MRP, 1, 1);
    chk("bp.pushpop_ovf", 32'(overflow), 32'd0);
    ev(CP, 1, 0);
    chk("bp.drop_ovf", 32'(overflow), 32'd1);
    chk("bp.perr", 32'(proto_err), 32'd0);
    for (int k = 0; k < 8; k++) begin
      pop($sformatf("bp.r%0d", k), bp_pass[k], bp_plane[k], 16'(k + 2), 1'b0);
    end
    chk("bp.empty", 32'(rec_valid), 32'd0);

    // Order error, then mid-block code-block restart
    syn(5'd4);
    chk("ord.ovf_cleared", 32'(overflow), 32'd0);
    bytes(2);
    ev(SP, 0, 0);
    chk("ord.perr",  32'(proto_err), 32'd1);
    chk("ord.pass",  32'(rec_pass),  32'd1);
    chk("ord.plane", 32'(rec_plane), 32'd4);
    chk("ord.len",   32'(rec_len),   32'd2);
    ev(CP, 0, 0);
    ev(SP, 0, 0);
    syn(5'd9);
    chk("mid.valid", 32'(rec_valid), 32'd0);
    chk("mid.perr",  32'(proto_err), 32'd0);
    chk("mid.ovf",   32'(overflow),  32'd0);
    bytes(3);
    ev(CP, 0, 0);
    pop("mid.cp", 2'b11, 5'd9, 16'd3, 1'b0);
    chk("mid.empty", 32'(rec_valid), 32'd0);

    // Saturation on the LEN_W=4 copy
    syn(5'd1);
    bytes(20);
    ev(CP, 0, 0);
    chk("sat.len4",  32'(s_len),   32'd15);
    chk("sat.pass4", 32'(s_pass),  32'd3);
    chk("sat.len16", 32'(rec_len), 32'd20);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;

    // Two edges in one cycle: only the later pass is kept
    syn(5'd2);
    wl_sp  = 1'b1;
    wl_mrp = 1'b1;
    tick();
    wl_sp  = 1'b0;
    wl_mrp = 1'b0;
    tick();
    chk("multi.perr", 32'(proto_err), 32'd1);
    pop("multi.mrp", 2'b10, 5'd2, 16'd0, 1'b0);
    chk("multi.single", 32'(rec_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
